// File: rtl/flag_update_unit.sv
// CPSR condition-flag register {C,N,V,Z} with SPSR flag shadow and a
// pending-S-bit-writer scoreboard that lets decode stall conditional instructions.
module flag_update_unit #(
    parameter int unsigned PEND_W      = 2,
    parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [31:0]       Alu_Result,
    input  logic              Alu_Carry,
    input  logic              Alu_Overflow,
    input  logic [1:0]        Op_Class,
    input  logic              S_Bit,
    input  logic              Cond_Pass,
    input  logic              Wb_Valid,
    input  logic              Issue_S,
    input  logic              Flush,
    input  logic              Msr_We,
    input  logic [3:0]        Msr_Data,
    input  logic              Exc_Entry,
    input  logic              Exc_Return,
    output logic [3:0]        Flags,
    output logic [3:0]        Saved_Flags,
    output logic              Flags_Busy,
    output logic [PEND_W-1:0] Pend_Count,
    output logic              Pend_Err
);

    typedef enum logic [1:0] {
        OP_LOGICAL = 2'b00,
        OP_ARITH   = 2'b01,
        OP_MUL     = 2'b10,
        OP_NONE    = 2'b11
    } op_class_e;

    localparam int unsigned C_BIT = 3;
    localparam int unsigned N_BIT = 2;
    localparam int unsigned V_BIT = 1;
    localparam int unsigned Z_BIT = 0;

    localparam logic [PEND_W-1:0] PEND_MAX  = '1;
    localparam logic [PEND_W-1:0] PEND_ZERO = '0;
    localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);

    op_class_e   op_class;
    logic        upd;
    logic [3:0]  calc_flags;
    logic [3:0]  flags_next;

    logic        inc;
    logic        dec;
    logic [PEND_W-1:0] pend_next;
    logic        err_set;

    assign op_class = op_class_e'(Op_Class);
    assign upd      = Wb_Valid & S_Bit & Cond_Pass & (op_class != OP_NONE);

    // Flags not produced by the current op class keep their register value.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
        calc_flags        = Flags;
        calc_flags[N_BIT] = Alu_Result[31];
        calc_flags[Z_BIT] = ~|Alu_Result;
        case (op_class)
            OP_LOGICAL: calc_flags[C_BIT] = Alu_Carry;
            OP_ARITH: begin
                calc_flags[C_BIT] = Alu_Carry;
                calc_flags[V_BIT] = Alu_Overflow;
            end
            default: ;
        endcase
    end

    always_comb begin
        flags_next = Flags;
        if (Exc_Return) begin
            flags_next = Saved_Flags;
        end else if (Msr_We) begin
            flags_next = Msr_Data;
        end else if (upd) begin
            flags_next = calc_flags;
        end
    end

    // Saved_Flags samples the pre-update register, so entry+return in one cycle swaps.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Flags       <= RESET_FLAGS;
            Saved_Flags <= RESET_FLAGS;
        end else begin
            // NOTE: non-blocking assignments make both registers see old values, giving the swap.
            Flags <= flags_next;
            if (Exc_Entry) begin
                Saved_Flags <= Flags;
            end
        end
    end

    // A retiring S-bit instruction decrements even when its condition failed.
    assign inc = Issue_S;
    assign dec = Wb_Valid & S_Bit;

    always_comb begin
        pend_next = Pend_Count;
        err_set   = 1'b0;
        if (Flush) begin
            pend_next = PEND_ZERO;
        end else if (inc && !dec) begin
            if (Pend_Count == PEND_MAX) begin
                err_set = 1'b1;
            end else begin
                pend_next = Pend_Count + PEND_ONE;
            end
        end else if (dec && !inc) begin
            if (Pend_Count == PEND_ZERO) begin
                err_set = 1'b1;
            end else begin
                pend_next = Pend_Count - PEND_ONE;
            end
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Pend_Count <= PEND_ZERO;
            Pend_Err   <= 1'b0;
        end else begin
            Pend_Count <= pend_next;
            if (err_set) begin
                Pend_Err <= 1'b1;
            end
        end
    end

    assign Flags_Busy = (Pend_Count != PEND_ZERO);

endmodule

// File: tb/tb_flag_update_unit.sv
// Scoreboard bench for flag_update_unit: the driver queues hand-computed expectations
// tagged with a target cycle, and a monitor compares them one cycle after issue.
module tb_flag_update_unit;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [31:0] Alu_Result;
    logic        Alu_Carry;
    logic        Alu_Overflow;
    logic [1:0]  Op_Class;
    logic        S_Bit;
    logic        Cond_Pass;
    logic        Wb_Valid;
    logic        Issue_S;
    logic        Flush;
    logic        Msr_We;
    logic [3:0]  Msr_Data;
    logic        Exc_Entry;
    logic        Exc_Return;
    logic [3:0]  Flags;
    logic [3:0]  Saved_Flags;
    logic        Flags_Busy;
    logic [1:0]  Pend_Count;
    logic        Pend_Err;

    always #5 Clk = ~Clk;

    flag_update_unit #(.PEND_W(2), .RESET_FLAGS(4'b0000)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .Alu_Result(Alu_Result), .Alu_Carry(Alu_Carry), .Alu_Overflow(Alu_Overflow),
        .Op_Class(Op_Class), .S_Bit(S_Bit), .Cond_Pass(Cond_Pass), .Wb_Valid(Wb_Valid),
        .Issue_S(Issue_S), .Flush(Flush), .Msr_We(Msr_We), .Msr_Data(Msr_Data),
        .Exc_Entry(Exc_Entry), .Exc_Return(Exc_Return),
        .Flags(Flags), .Saved_Flags(Saved_Flags), .Flags_Busy(Flags_Busy),
        .Pend_Count(Pend_Count), .Pend_Err(Pend_Err)
    );

    typedef struct {
        string      name;
        int         cyc;
        logic [3:0] flags;
        logic [3:0] saved;
        logic [1:0] cnt;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] f, input logic [3:0] s,
                             input logic [1:0] c, input logic e);
        check({name, ".flags"}, 32'(Flags), 32'(f));
        check({name, ".saved"}, 32'(Saved_Flags), 32'(s));
        check({name, ".count"}, 32'(Pend_Count), 32'(c));
        check({name, ".busy"},  32'(Flags_Busy), 32'(c != 2'd0));
        check({name, ".err"},   32'(Pend_Err), 32'(e));
    endtask

    // Monitor: on each edge, compare every expectation due this cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge Clk);
            cyc++;
            #1;
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                e = sb.pop_front();
                check_all(e.name, e.flags, e.saved, e.cnt, e.err);
            end
        end
    end

    task automatic idle();
        Alu_Result = 32'h0; Alu_Carry = 1'b0; Alu_Overflow = 1'b0; Op_Class = 2'b11;
        S_Bit = 1'b0; Cond_Pass = 1'b0; Wb_Valid = 1'b0; Issue_S = 1'b0; Flush = 1'b0;
        Msr_We = 1'b0; Msr_Data = 4'h0; Exc_Entry = 1'b0; Exc_Return = 1'b0;
    endtask

    // Writeback of an S-bit instruction, paired with a new issue so the count is balanced.
    task automatic wb(input logic [1:0] op, input logic [31:0] res, input logic c,
                      input logic v, input logic cp);
        Wb_Valid = 1'b1; S_Bit = 1'b1; Issue_S = 1'b1; Op_Class = op;
        Alu_Result = res; Alu_Carry = c; Alu_Overflow = v; Cond_Pass = cp;
    endtask

    task automatic expect_next(input string name, input logic [3:0] f, input logic [3:0] s,
                               input logic [1:0] c, input logic e);
        exp_t x;
        x.name = name; x.cyc = cyc + 1; x.flags = f; x.saved = s; x.cnt = c; x.err = e;
        sb.push_back(x);
        @(negedge Clk);
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        Reset_n = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        check_all("reset_init", 4'b0000, 4'b0000, 2'd0, 1'b0);
        Reset_n = 1'b1;

        // Flag computation
        wb(2'b01, 32'h0, 1'b1, 1'b0, 1'b0);
        expect_next("arith_cond_fail", 4'b0000, 4'b0000, 2'd0, 1'b0);
        wb(2'b01, 32'h0, 1'b1, 1'b0, 1'b1);
        expect_next("arith_zero_carry", 4'b1001, 4'b0000, 2'd0, 1'b0);
        Msr_We = 1'b1; Msr_Data = 4'b0010;
        expect_next("msr_set_v", 4'b0010, 4'b0000, 2'd0, 1'b0);
        wb(2'b00, 32'h8000_0000, 1'b0, 1'b1, 1'b1);
        expect_next("logical_neg", 4'b0110, 4'b0000, 2'd0, 1'b0);
        wb(2'b10, 32'h1, 1'b1, 1'b1, 1'b1);
        expect_next("mul_keep_cv", 4'b0010, 4'b0000, 2'd0, 1'b0);
        wb(2'b11, 32'h0, 1'b1, 1'b1, 1'b1);
        expect_next("noflag_class", 4'b0010, 4'b0000, 2'd0, 1'b0);

        // Priority
        wb(2'b01, 32'h0, 1'b0, 1'b1, 1'b1);
        Msr_We = 1'b1; Msr_Data = 4'b1010;
        expect_next("msr_over_upd", 4'b1010, 4'b0000, 2'd0, 1'b0);
        Exc_Return = 1'b1; Msr_We = 1'b1; Msr_Data = 4'b1111;
        expect_next("ret_over_msr", 4'b0000, 4'b0000, 2'd0, 1'b0);

        // Exception save/restore
        Msr_We = 1'b1; Msr_Data = 4'b0101;
        expect_next("msr_0101", 4'b0101, 4'b0000, 2'd0, 1'b0);
        wb(2'b01, 32'h1, 1'b1, 1'b0, 1'b1);
        Exc_Entry = 1'b1;
        expect_next("entry_with_upd", 4'b1000, 4'b0101, 2'd0, 1'b0);
        Exc_Return = 1'b1;
        expect_next("exc_return", 4'b0101, 4'b0101, 2'd0, 1'b0);
        Msr_We = 1'b1; Msr_Data = 4'b0011;
        expect_next("msr_0011", 4'b0011, 4'b0101, 2'd0, 1'b0);
        Exc_Entry = 1'b1; Exc_Return = 1'b1;
        expect_next("entry_return_swap", 4'b0101, 4'b0011, 2'd0, 1'b0);

        // Scoreboard
        Issue_S = 1'b1;
        expect_next("issue_1", 4'b0101, 4'b0011, 2'd1, 1'b0);
        Issue_S = 1'b1;
        expect_next("issue_2", 4'b0101, 4'b0011, 2'd2, 1'b0);
        Issue_S = 1'b1;
        expect_next("issue_3", 4'b0101, 4'b0011, 2'd3, 1'b0);
        Issue_S = 1'b1;
        expect_next("issue_sat", 4'b0101, 4'b0011, 2'd3, 1'b1);
        wb(2'b01, 32'h0, 1'b1, 1'b1, 1'b0);
        expect_next("issue_and_dec", 4'b0101, 4'b0011, 2'd3, 1'b1);
        Wb_Valid = 1'b1; S_Bit = 1'b1; Cond_Pass = 1'b0; Op_Class = 2'b01;
        expect_next("dec_cond_fail", 4'b0101, 4'b0011, 2'd2, 1'b1);
        Flush = 1'b1; Issue_S = 1'b1;
        expect_next("flush", 4'b0101, 4'b0011, 2'd0, 1'b1);
        Wb_Valid = 1'b1; S_Bit = 1'b1; Cond_Pass = 1'b0; Op_Class = 2'b01;
        expect_next("dec_at_zero", 4'b0101, 4'b0011, 2'd0, 1'b1);

        // Asynchronous reset in the middle of a cycle
        Msr_We = 1'b1; Msr_Data = 4'b1111; Issue_S = 1'b1;
        expect_next("pre_reset", 4'b1111, 4'b0011, 2'd1, 1'b1);
        #2;
        Reset_n = 1'b0;
        #1;
        check_all("async_reset", 4'b0000, 4'b0000, 2'd0, 1'b0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_update_unit.md
Name: flag_update_unit

Overview:
- Produces and holds the CPSR condition flags that the condition checker consumes. Output `Flags` is packed {C,N,V,Z} in bits [3:0].
- Computes N/Z/C/V from ALU writeback results and updates them on S-bit instructions whose condition passed.
- Also handles MSR flag writes and exception save/restore of the flags (SPSR shadow).
- Keeps a pending-flag-writer scoreboard so decode can stall conditional instructions while an S-bit instruction is still in flight.

Parameters:
- PEND_W, 2, width of the pending-writer counter; maximum in-flight S-bit instructions = 2^PEND_W-1.
- RESET_FLAGS, 4'b0000, value loaded into `Flags` and `Saved_Flags` at reset ({C,N,V,Z}).

Ports:
- Clk  input  1  system clock, rising edge.
- Reset_n  input  1  asynchronous, active-low reset.
- Alu_Result  input  32  writeback result.
- Alu_Carry  input  1  adder carry-out (arith) or shifter carry-out (logical).
- Alu_Overflow  input  1  adder signed overflow.
- Op_Class  input  2  00 logical, 01 arithmetic, 10 multiply, 11 no-flag.
- S_Bit  input  1  writeback instruction has S set.
- Cond_Pass  input  1  condition checker result for the writeback instruction.
- Wb_Valid  input  1  writeback stage holds a valid instruction this cycle.
- Issue_S  input  1  an S-bit instruction leaves decode this cycle.
- Flush  input  1  pipeline flush; discards in-flight S-bit instructions.
- Msr_We  input  1  MSR flag-field write.
- Msr_Data  input  4  new flags {C,N,V,Z}.
- Exc_Entry  input  1  exception taken: save flags.
- Exc_Return  input  1  exception return: restore flags.
- Flags  output  4  current {C,N,V,Z}, registered.
- Saved_Flags  output  4  SPSR flag shadow, registered.
- Flags_Busy  output  1  pending counter non-zero; combinational from the counter register.
- Pend_Count  output  PEND_W  pending S-bit writers.
- Pend_Err  output  1  sticky scoreboard error.

Behaviour:
- Reset (Reset_n=0, asynchronous, including mid-operation):
  - `Flags` = `Saved_Flags` = RESET_FLAGS.
  - `Pend_Count` = 0, `Flags_Busy` = 0, `Pend_Err` = 0.
- Update enable: `upd` = Wb_Valid & S_Bit & Cond_Pass & (Op_Class != 11).
- Computed flags, one cycle latency (visible on `Flags` the edge after writeback):
  - N = Alu_Result[31].
  - Z = (Alu_Result == 0).
  - Logical (00): C = Alu_Carry; V unchanged.
  - Arithmetic (01): C = Alu_Carry; V = Alu_Overflow.
  - Multiply (10): C and V unchanged.
- Flags next-state priority, highest first: Exc_Return (`Flags` <= `Saved_Flags`) > Msr_We (`Flags` <= Msr_Data) > `upd` > hold.
  - A lower-priority event in the same cycle is dropped.
- Saved_Flags:
  - On Exc_Entry: `Saved_Flags` <= current `Flags` register value (pre-update), even if an update or MSR lands on `Flags` in the same cycle.
  - Exc_Entry and Exc_Return in the same cycle: restore uses the old `Saved_Flags`, then `Saved_Flags` takes the old `Flags` (swap).
- Scoreboard:
  - inc = Issue_S; dec = Wb_Valid & S_Bit. Dec applies regardless of Cond_Pass, because a failed-condition instruction still retires.
  - Flush: counter <= 0; overrides inc/dec.
  - inc & dec together: counter unchanged.
  - inc at maximum: counter saturates and `Pend_Err` <= 1.
  - dec at 0: counter stays 0 and `Pend_Err` <= 1.
  - `Pend_Err` clears only on reset.
- `Flags_Busy` = (`Pend_Count` != 0). Decode stalls any conditional instruction (cond != AL) while `Flags_Busy` is high.
- No combinational path from any input to `Flags` or `Saved_Flags`.

Test Plan:
- Reset: Reset_n=0 mid-cycle with `Flags`=4'b1111 -> `Flags`=0000, `Pend_Count`=0, `Pend_Err`=0 immediately, without waiting for a clock edge.
- Arithmetic update: Op_Class=01, Alu_Result=0, Carry=1, Overflow=0, S=1, Cond_Pass=1, Wb_Valid=1 -> next edge `Flags`=4'b1001.
  - Same stimulus with Cond_Pass=0 -> `Flags` unchanged.
- Logical/multiply: `Flags`=4'b0010 (V=1); logical result 32'h8000_0000, Carry=0 -> `Flags`=4'b0110.
  - Then multiply with result 1 and Carry=1 -> `Flags`=4'b0010 (C and V preserved).
- Priority: Msr_We=1, Msr_Data=4'b1010, with a simultaneous valid update -> `Flags`=1010.
  - Exc_Return together with Msr_We -> `Flags` = `Saved_Flags`.
- Exception: `Flags`=0101, Exc_Entry with a simultaneous update to 1000 -> `Saved_Flags`=0101, `Flags`=1000.
  - Then Exc_Return -> `Flags`=0101.
- Scoreboard (PEND_W=2): 3 Issue_S pulses -> `Pend_Count`=3, `Flags_Busy`=1.
  - 4th pulse -> count stays 3, `Pend_Err`=1.
  - Issue_S together with dec -> count 3.
  - Flush -> count 0, `Flags_Busy`=0, `Pend_Err` stays 1.
